// File: rtl/conv1_window_ctrl.sv
// conv1_window_ctrl: raster-scan sequencer that feeds a 3x3 line buffer and flags complete windows
module conv1_window_ctrl #(
  parameter int IMG_W       = 30,
  parameter int IMG_H       = 30,
  parameter int KERNEL_SIZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       buf_shift_en,
  output logic [7:0] buf_data,
  output logic       win_valid,
  output logic [4:0] win_row,
  output logic [4:0] win_col,
  output logic       busy,
  output logic       frame_done
);
  localparam logic [4:0] COL_LAST = 5'(IMG_W - 1);
  localparam logic [4:0] ROW_LAST = 5'(IMG_H - 1);
  localparam logic [4:0] K_LAST   = 5'(KERNEL_SIZE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state_q;
  logic [4:0] row_q, col_q, row_d, col_d;
  logic       accept, col_wrap, last_px, win_hit;
  assign in_ready     = (state_q == RUN) && out_ready;
  assign accept       = in_valid && in_ready;
  assign buf_shift_en = accept;
  assign buf_data     = in_data;
  assign busy         = state_q != IDLE;
  // next raster position; the final pixel parks the counters instead of overflowing the row
  always_comb begin
    col_wrap = col_q == COL_LAST;
    last_px  = col_wrap && (row_q == ROW_LAST);
    win_hit  = accept && (row_q >= K_LAST) && (col_q >= K_LAST);
    col_d    = accept ? (col_wrap ? 5'd0 : col_q + 5'd1) : col_q;
    row_d    = (accept && col_wrap && !last_px) ? row_q + 5'd1 : row_q;
  end
  // frame FSM with registered window flag, coordinates and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= win_hit;
      frame_done <= 1'b0;
      if (win_hit) begin
        win_row <= row_q - K_LAST;
        win_col <= col_q - K_LAST;
      end
      unique case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          row_q   <= '0;
          col_q   <= '0;
        end
        RUN: begin
          row_q <= row_d;
          col_q <= col_d;
          if (accept && last_px) begin
            state_q    <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv1_window_ctrl.md
CONV1_WINDOW_CTRL -- requirements
Module: conv1_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 30: feature-map width in pixels, which is also the line-buffer row pitch.
REQ-002 Parameter IMG_H, default 30: feature-map height in rows.
REQ-003 Parameter KERNEL_SIZE, default 3: window edge length; the line buffer depth is (KERNEL_SIZE-1)*IMG_W+KERNEL_SIZE = 63.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins a frame.
REQ-007 in_valid  input  1  upstream pixel valid.
REQ-008 in_data  input  8  upstream pixel value.
REQ-009 in_ready  output  1  block can accept a pixel this cycle.
REQ-010 out_ready  input  1  downstream convolution engine can take a window.
REQ-011 buf_shift_en  output  1  shift enable to the 63-entry line buffer.
REQ-012 buf_data  output  8  pixel driven into line buffer entry 0.
REQ-013 win_valid  output  1  the line buffer taps hold a complete 3x3 window.
REQ-014 win_row  output  5  top-left row of the current window, range 0..IMG_H-KERNEL_SIZE.
REQ-015 win_col  output  5  top-left column of the current window, range 0..IMG_W-KERNEL_SIZE.
REQ-016 busy  output  1  high while a frame is in progress.
REQ-017 frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 The FSM SHALL go from IDLE to RUN when start=1, clearing row_cnt and col_cnt to 0 on that edge.
REQ-020 The FSM SHALL go from RUN to DONE on the edge that accepts pixel (IMG_H-1, IMG_W-1).
REQ-021 The FSM SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-022 start SHALL be ignored in the RUN and DONE states.
REQ-023 in_ready SHALL be combinational: (state==RUN) && out_ready.
REQ-024 A pixel SHALL be accepted when accept = in_valid && in_ready.
REQ-025 buf_shift_en SHALL equal accept, combinationally.
REQ-026 buf_data SHALL equal in_data, combinationally.
REQ-027 With no accept, the line buffer SHALL not shift and the counters SHALL hold.
REQ-028 On accept, col_cnt SHALL increment; when col_cnt==IMG_W-1 it SHALL wrap to 0 and row_cnt SHALL increment.
REQ-029 row_cnt and col_cnt SHALL never exceed IMG_H-1 and IMG_W-1 respectively.
REQ-030 win_valid SHALL be registered: it is 1 in the cycle after an accept of pixel (r,c) with r>=KERNEL_SIZE-1 and c>=KERNEL_SIZE-1, and 0 otherwise.
REQ-031 win_valid SHALL be a single-cycle pulse per qualifying accept.
REQ-032 Windows that wrap across a row boundary (c<2) SHALL never be flagged valid.
REQ-033 win_row and win_col SHALL be registered alongside win_valid with values r-2 and c-2.
REQ-034 win_row and win_col SHALL hold their last value while win_valid=0.
REQ-035 Each frame SHALL produce exactly (IMG_H-2)*(IMG_W-2) = 784 win_valid pulses, in raster order.
REQ-036 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-037 frame_done SHALL be 1 only in the DONE state, coinciding with the final win_valid (win_row=27, win_col=27).
REQ-038 When out_ready=0, in_ready SHALL drop in the same cycle, no accept occurs, and no new win_valid is produced in the following cycle.
REQ-039 When in_valid=0 in RUN, the block SHALL produce a bubble: counters and buffer hold, and win_valid=0 in the next cycle.
REQ-040 When start and rst are both 1, rst SHALL win.

Reset
REQ-041 When rst=1 at a rising edge, the block SHALL go to IDLE and clear row_cnt, col_cnt, win_valid, win_row, win_col and frame_done to 0.
REQ-042 After reset, busy=0 and in_ready=0.
REQ-043 A reset mid-frame SHALL abort the frame with no frame_done pulse; the next start SHALL begin a fresh frame from (0,0).
REQ-044 The block SHALL not clear the line buffer contents; stale data is flushed because win_valid requires two full rows to be accepted first.

Verification
REQ-045 Reset, then start, then 900 pixels (value = index mod 256) with in_valid=1 and out_ready=1 -> first win_valid 1 cycle after accept #62 with (0,0); 784 pulses total; frame_done together with (27,27); busy falls 1 cycle later.
REQ-046 Hold out_ready=0 for 5 cycles mid-row -> in_ready=0, buf_shift_en=0, no win_valid, counters unchanged; the stream resumes with no lost or duplicated window.
REQ-047 Drop in_valid every other cycle -> the same 784 windows with identical coordinates, spaced at 2-cycle intervals.
REQ-048 Accept pixels 60..61 (row 2, cols 0..1) -> no win_valid; pixel 62 -> win_valid with (0,0); pixel 90 (row 3, col 0) -> no win_valid.
REQ-049 Assert rst after 400 accepts, then start -> state IDLE, outputs 0, no frame_done; the new frame's first window appears after accept #62 with (0,0).
REQ-050 Pulse start during RUN and drive in_valid while IDLE -> no effect: counts unchanged and no buf_shift_en.
